// File: rtl/c17_prob_monitor.sv
// c17_prob_monitor
//   Observes the c17 netlist primary outputs (bit 0 = N22, bit 1 = N23) over a
//   window of 2^SAMPLE_LOG2 accepted samples. It counts ones per channel, which
//   gives an empirical signal probability in Q1.SAMPLE_LOG2 fixed point.
//   An optional 16-bit MISR compacts the same response stream.
//
//   Configuration macro: C17_PROB_MON_MISR_EN
//     defined   -> MISR built (poly 0x1021, seed 0xFFFF)
//     undefined -> no MISR logic, o_misr_sig tied to 0
//
// Ports
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_start     begin a window (accepted in IDLE or DONE, ignored in RUN)
//   i_clr       synchronous abort to IDLE with results zeroed; beats start/valid
//   i_in_valid  i_in_data holds a settled response this cycle
//   i_in_data   netlist output sample, NUM_CH bits
//   o_busy      high in RUN
//   o_done      high in DONE, results stable
//   o_ones_cnt  per-channel ones counts, channel k at [k*CNT_W +: CNT_W]
//   o_misr_sig  response signature
module c17_prob_monitor #(
  parameter int NUM_CH      = 2,
  parameter int SAMPLE_LOG2 = 8,
  parameter int CNT_W       = SAMPLE_LOG2 + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_clr,
  input  logic                    i_in_valid,
  input  logic [NUM_CH-1:0]       i_in_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NUM_CH*CNT_W-1:0] o_ones_cnt,
  output logic [15:0]             o_misr_sig
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Index of the final sample in a window; one extra MSB so the count never wraps.
  localparam logic [SAMPLE_LOG2:0] LAST_IDX = {1'b0, {SAMPLE_LOG2{1'b1}}};

  state_t                          r_state, w_state_nxt;
  logic [SAMPLE_LOG2:0]            r_smp_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]    r_ones;
  logic                            w_accept, w_last, w_restart;

  // clr wins everywhere; start only clears when it is actually honoured.
  assign w_restart = i_clr || (i_start && (r_state != S_RUN));
  assign w_accept  = (r_state == S_RUN) && i_in_valid && !i_clr;
  assign w_last    = w_accept && (r_smp_cnt == LAST_IDX);

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_clr) w_state_nxt = S_IDLE; else if (i_start) w_state_nxt = S_RUN;
      S_RUN:   if (i_clr) w_state_nxt = S_IDLE; else if (w_last)  w_state_nxt = S_DONE;
      S_DONE:  if (i_clr) w_state_nxt = S_IDLE; else if (i_start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // outputs decode the state register only, so nothing is combinational from inputs
  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_smp_cnt <= '0;
    else if (w_restart) r_smp_cnt <= '0;
    else if (w_accept)  r_smp_cnt <= r_smp_cnt + 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                        r_ones[k] <= '0;
      else if (w_restart)               r_ones[k] <= '0;
      else if (w_accept && i_in_data[k]) r_ones[k] <= r_ones[k] + 1'b1;
    end
  end

  assign o_ones_cnt = r_ones;

`ifdef C17_PROB_MON_MISR_EN
  logic [15:0] r_misr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_misr <= 16'hFFFF;
    else if (w_restart) r_misr <= 16'hFFFF;
    else if (w_accept)
      r_misr <= {r_misr[14:0], 1'b0} ^ (r_misr[15] ? 16'h1021 : 16'h0000) ^ 16'(i_in_data);
  end

  assign o_misr_sig = r_misr;
`else
  assign o_misr_sig = 16'h0000;
`endif

endmodule

// File: tb/tb_c17_prob_monitor.sv
module tb_c17_prob_monitor;

  logic       clk = 1'b0;
  logic       rst, start, clr, vld;
  logic [1:0] din;
  logic       busy4, done4, busy5, done5;
  logic [9:0] cnt4;
  logic [11:0] cnt5;
  logic [15:0] misr4, misr5;

  int checks = 0;
  int errors = 0;

`ifdef C17_PROB_MON_MISR_EN
  localparam logic [15:0] MISR_RST = 16'hFFFF;
  localparam logic [15:0] MISR_ONE00 = 16'hEFDF;
`else
  localparam logic [15:0] MISR_RST = 16'h0000;
  localparam logic [15:0] MISR_ONE00 = 16'h0000;
`endif

  always #5 clk = ~clk;

  c17_prob_monitor #(.NUM_CH(2), .SAMPLE_LOG2(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clr(clr), .i_in_valid(vld),
    .i_in_data(din), .o_busy(busy4), .o_done(done4), .o_ones_cnt(cnt4),
    .o_misr_sig(misr4));

  c17_prob_monitor #(.NUM_CH(2), .SAMPLE_LOG2(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clr(clr), .i_in_valid(vld),
    .i_in_data(din), .o_busy(busy5), .o_done(done5), .o_ones_cnt(cnt5),
    .o_misr_sig(misr5));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // c17 netlist: returns {N23, N22}; v = {N1,N2,N3,N6,N7}
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = v;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] s, input logic [1:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, d};
  endfunction

  typedef struct {
    logic [15:0] d0;   // ch0 value of sample i at bit i
    logic [15:0] d1;
    bit          gap;  // valid on every other RUN cycle
    int          e0;
    int          e1;
    int          ecyc; // RUN cycles from busy rise to done rise
  } vec_t;

  vec_t vt[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, smp, c0, c1;
    logic [15:0] m;

    vt[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 16, 16, 16};
    vt[1] = '{16'h5555, 16'h0000, 1'b0,  8,  0, 16};
    vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16, 16, 32};
    vt[3] = '{16'h00FF, 16'h0F0F, 1'b1,  8,  8, 32};
    vt[4] = '{16'h0000, 16'h8001, 1'b0,  0,  2, 16};

    rst = 1'b1; start = 1'b0; clr = 1'b0; vld = 1'b0; din = 2'b00;
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_cnt", cnt4, 0);
    chk("rst_misr", misr4, MISR_RST);
    @(negedge clk) rst = 1'b0;

    // table-driven windows; each later entry starts from DONE (back-to-back)
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk($sformatf("v%0d_busy_rise", i), busy4, 1);
      cyc = 0; smp = 0;
      while (!done4 && cyc < 100) begin
        vld = (smp < 16) && (!vt[i].gap || cyc[0]);
        if (vld) begin
          din = {vt[i].d1[smp], vt[i].d0[smp]};
          smp++;
        end
        @(negedge clk);
        cyc++;
      end
      vld = 1'b0;
      chk($sformatf("v%0d_cycles", i), cyc, vt[i].ecyc);
      chk($sformatf("v%0d_ch0", i), cnt4[4:0], vt[i].e0);
      chk($sformatf("v%0d_ch1", i), cnt4[9:5], vt[i].e1);
      chk($sformatf("v%0d_busy", i), busy4, 0);
      chk($sformatf("v%0d_done", i), done4, 1);
    end

    // results hold in DONE while more valid samples arrive
    vld = 1'b1; din = 2'b11;
    repeat (3) @(negedge clk);
    vld = 1'b0;
    chk("hold_ch1", cnt4[9:5], 2);
    chk("hold_ch0", cnt4[4:0], 0);
    chk("hold_done", done4, 1);

    // start and clr together in DONE -> IDLE
    start = 1'b1; clr = 1'b1;
    @(negedge clk) begin start = 1'b0; clr = 1'b0; end
    chk("stclr_busy", busy4, 0);
    chk("stclr_done", done4, 0);
    chk("stclr_cnt", cnt4, 0);

    // start mid-RUN is ignored, then clr aborts
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int s = 0; s < 5; s++) begin
      vld = 1'b1; din = 2'b01; start = (s == 2);
      @(negedge clk);
      if (s == 0) chk("first_sample_lat", cnt4[4:0], 1);
    end
    vld = 1'b0; start = 1'b0;
    chk("midstart_ch0", cnt4[4:0], 5);
    chk("midstart_ch1", cnt4[9:5], 0);
    chk("midstart_busy", busy4, 1);
    clr = 1'b1; start = 1'b1; vld = 1'b1;
    @(negedge clk) begin clr = 1'b0; start = 1'b0; vld = 1'b0; end
    chk("clr_busy", busy4, 0);
    chk("clr_done", done4, 0);
    chk("clr_cnt", cnt4, 0);
    chk("clr_misr", misr4, MISR_RST);
    @(negedge clk);
    chk("clr_stay_idle", busy4, 0);

    // async reset mid-RUN clears immediately, before any clock edge
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    vld = 1'b1; din = 2'b11;
    repeat (3) @(negedge clk);
    vld = 1'b0;
    chk("partial_ch0", cnt4[4:0], 3);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", busy4, 0);
    chk("arst_done", done4, 0);
    chk("arst_cnt", cnt4, 0);
    chk("arst_misr", misr4, MISR_RST);
    @(negedge clk) rst = 1'b0;

    // single zero sample -> signature
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; vld = 1'b1; din = 2'b00; end
    @(negedge clk) vld = 1'b0;
    chk("misr_one00", misr4, MISR_ONE00);
    chk("misr_one00_busy", busy4, 1);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;

    // exhaustive c17 drive on the 32-sample instance
    c0 = 0; c1 = 0; m = 16'hFFFF;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int v = 0; v < 32; v++) begin
      vld = 1'b1; din = c17(5'(v));
      c0 += din[0]; c1 += din[1];
      m = mstep(m, din);
      @(negedge clk);
    end
    vld = 1'b0;
`ifndef C17_PROB_MON_MISR_EN
    m = 16'h0000;
`endif
    chk("c17_n22", cnt5[5:0], c0);
    chk("c17_n23", cnt5[11:6], c1);
    chk("c17_done", done5, 1);
    chk("c17_busy", busy5, 0);
    chk("c17_misr", misr5, m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
